// File: rtl/sd_cmd_sequencer_if.sv
// rtl/sd_cmd_sequencer_if.sv - host register bus and completion status of the SD command sequencer
interface sd_cmd_sequencer_if;
  logic [31:0] reg_address;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        req;
  logic        busy;
  logic        cmd_done;
  logic        timeout_err;
  logic        crc_err;
  logic        end_err;
  logic        index_err;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;

  modport master (
    output reg_address, reg_wr_data, reg_wr_en, req,
    input  busy, cmd_done, timeout_err, crc_err, end_err, index_err, rsp_index, rsp_arg
  );

  modport slave (
    input  reg_address, reg_wr_data, reg_wr_en, req,
    output busy, cmd_done, timeout_err, crc_err, end_err, index_err, rsp_index, rsp_arg
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD CMD-line sequencer: frame send with CRC7, response capture and checks
module sd_cmd_sequencer #(
  parameter int TIMEOUT_BITS = 64,
  parameter int TURN_BITS    = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                bit_en,
  input  logic                cmd_in,
  output logic                cmd_out,
  output logic                cmd_oe,
  sd_cmd_sequencer_if.slave   host
);

  localparam int TURN_W = $clog2(TURN_BITS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_TURN,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         arg_q, arg_d;
  logic [5:0]          index_q, index_d;
  logic [1:0]          rsp_type_q, rsp_type_d;
  logic [39:0]         tx_sh_q, tx_sh_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          crc_q, crc_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [47:0]         rx_q, rx_d;
  logic                got_rsp_q, got_rsp_d;
  logic                cmd_out_q, cmd_out_d;
  logic                cmd_oe_q, cmd_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmo_err_q, tmo_err_d;
  logic                crc_err_q, crc_err_d;
  logic                end_err_q, end_err_d;
  logic                idx_err_q, idx_err_d;
  logic [5:0]          rsp_index_q, rsp_index_d;
  logic [31:0]         rsp_arg_q, rsp_arg_d;

  logic                wr;
  logic [11:0]         addr;
  logic                unused_ok;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Register writes are dropped entirely while a command is in flight, including the cmd_done cycle.
  assign wr        = host.req & host.reg_wr_en & ~busy_q;
  assign addr      = host.reg_address[11:0];
  assign unused_ok = ^{host.reg_address[31:12], host.reg_wr_data[31:16], rx_q[47:46]};

  always_comb begin
    state_d     = state_q;
    arg_d       = arg_q;
    index_d     = index_q;
    rsp_type_d  = rsp_type_q;
    tx_sh_d     = tx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    crc_d       = crc_q;
    turn_cnt_d  = turn_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    rx_d        = rx_q;
    got_rsp_d   = got_rsp_q;
    cmd_out_d   = cmd_out_q;
    cmd_oe_d    = cmd_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tmo_err_d   = tmo_err_q;
    crc_err_d   = crc_err_q;
    end_err_d   = end_err_q;
    idx_err_d   = idx_err_q;
    rsp_index_d = rsp_index_q;
    rsp_arg_d   = rsp_arg_q;

    if (wr && addr == 12'h008) arg_d[15:0]  = host.reg_wr_data[15:0];
    if (wr && addr == 12'h00A) arg_d[31:16] = host.reg_wr_data[15:0];

    case (state_q)
      S_IDLE: begin
        cmd_out_d = 1'b1;
        cmd_oe_d  = 1'b0;
        busy_d    = 1'b0;
        if (wr && addr == 12'h00E) begin
          index_d    = host.reg_wr_data[13:8];
          rsp_type_d = host.reg_wr_data[1:0];
          tx_sh_d    = {2'b01, host.reg_wr_data[13:8], arg_q};
          bit_cnt_d  = 6'd48;
          crc_d      = 7'h00;
          busy_d     = 1'b1;
          got_rsp_d  = 1'b0;
          tmo_err_d  = 1'b0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
          idx_err_d  = 1'b0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        if (bit_en) begin
          if (bit_cnt_q != 6'd0) begin
            // bit_cnt_q = k presents frame bit k-1: 40 data bits, 7 CRC bits, end bit.
            cmd_oe_d  = 1'b1;
            bit_cnt_d = bit_cnt_q - 6'd1;
            if (bit_cnt_q >= 6'd9) begin
              cmd_out_d = tx_sh_q[39];
              crc_d     = crc7_step(crc_q, tx_sh_q[39]);
              tx_sh_d   = {tx_sh_q[38:0], 1'b0};
            end else if (bit_cnt_q >= 6'd2) begin
              cmd_out_d = crc_q[6];
              crc_d     = {crc_q[5:0], 1'b0};
            end else begin
              cmd_out_d = 1'b1;
            end
          end else begin
            cmd_oe_d   = 1'b0;
            cmd_out_d  = 1'b1;
            turn_cnt_d = TURN_W'(TURN_BITS);
            state_d    = (rsp_type_q == 2'b00) ? S_DONE : S_TURN;
          end
        end
      end

      S_TURN: begin
        if (bit_en) begin
          if (turn_cnt_q <= TURN_W'(1)) begin
            tmo_cnt_d = TMO_W'(TIMEOUT_BITS);
            state_d   = S_WAIT;
          end else begin
            turn_cnt_d = turn_cnt_q - TURN_W'(1);
          end
        end
      end

      S_WAIT: begin
        if (bit_en) begin
          if (!cmd_in) begin
            // Start bit lands in rx_q[0] and ends up at bit 47; CRC of a leading 0 from 0 stays 0.
            rx_d      = '0;
            crc_d     = 7'h00;
            bit_cnt_d = 6'd47;
            got_rsp_d = 1'b1;
            state_d   = S_RECV;
          end else if (tmo_cnt_q <= TMO_W'(1)) begin
            tmo_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
          end
        end
      end

      S_RECV: begin
        if (bit_en) begin
          rx_d      = {rx_q[46:0], cmd_in};
          bit_cnt_d = bit_cnt_q - 6'd1;
          if (bit_cnt_q >= 6'd9) crc_d = crc7_step(crc_q, cmd_in);
          if (bit_cnt_q == 6'd1) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (got_rsp_q) begin
          end_err_d   = ~rx_q[0];
          crc_err_d   = (rx_q[7:1] != crc_q) && (rsp_type_q != 2'b11);
          idx_err_d   = (rx_q[45:40] != index_q) && (rsp_type_q != 2'b11);
          rsp_index_d = rx_q[45:40];
          rsp_arg_d   = rx_q[39:8];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      arg_q       <= '0;
      index_q     <= '0;
      rsp_type_q  <= '0;
      tx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      crc_q       <= '0;
      turn_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      rx_q        <= '0;
      got_rsp_q   <= 1'b0;
      cmd_out_q   <= 1'b1;
      cmd_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      end_err_q   <= 1'b0;
      idx_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_arg_q   <= '0;
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      index_q     <= index_d;
      rsp_type_q  <= rsp_type_d;
      tx_sh_q     <= tx_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      crc_q       <= crc_d;
      turn_cnt_q  <= turn_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rx_q        <= rx_d;
      got_rsp_q   <= got_rsp_d;
      cmd_out_q   <= cmd_out_d;
      cmd_oe_q    <= cmd_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_err_q   <= tmo_err_d;
      crc_err_q   <= crc_err_d;
      end_err_q   <= end_err_d;
      idx_err_q   <= idx_err_d;
      rsp_index_q <= rsp_index_d;
      rsp_arg_q   <= rsp_arg_d;
    end
  end

  assign cmd_out          = cmd_out_q;
  assign cmd_oe           = cmd_oe_q;
  assign host.busy        = busy_q;
  assign host.cmd_done    = done_q;
  assign host.timeout_err = tmo_err_q;
  assign host.crc_err     = crc_err_q;
  assign host.end_err     = end_err_q;
  assign host.index_err   = idx_err_q;
  assign host.rsp_index   = rsp_index_q;
  assign host.rsp_arg     = rsp_arg_q;

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Command-line controller for the SD host. It decodes host register writes to the argument registers (0x008, 0x00A) and the command register (0x00E). A write to 0x00E launches a 48-bit command frame with a generated CRC7 on the CMD line. It then releases the line, waits for the card's response under a timeout, deserializes and checks the response, and reports completion to the host-side control logic.

## Interface
Parameters:
- TIMEOUT_BITS, 64: bit-times allowed between command end bit and response start bit.
- TURN_BITS, 2: bit-times the line is released before start-bit search begins (Ncr minimum).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- bit_en  in  1  SD bit-rate enable; all CMD-line activity advances only on cycles with bit_en=1.
- reg_address  in  32  host register address; bits [11:0] decoded.
- reg_wr_data  in  32  host write data.
- reg_wr_en  in  1  write strobe.
- req  in  1  host request qualifier; a write occurs when req & reg_wr_en.
- cmd_in  in  1  CMD line from card, idle high.
- cmd_out  out  1  CMD line drive value.
- cmd_oe  out  1  CMD line output enable.
- busy  out  1  high from accepted issue until the cmd_done cycle, inclusive.
- cmd_done  out  1  one-CLK pulse at end of command.
- timeout_err, crc_err, end_err, index_err  out  1 each  status; valid and held from cmd_done until the next issue.
- rsp_index  out  6  received response index.
- rsp_arg  out  32  received response bits [39:8].

## Operation
- Register writes:
  - 0x008: arg[15:0] <= wr_data[15:0].
  - 0x00A: arg[31:16] <= wr_data[15:0].
  - 0x00E: index <= wr_data[13:8] and rsp_type <= wr_data[1:0]; starts the command.
  - Writes to any of these while busy=1 are ignored entirely.
- rsp_type decode:
  - 00: no response.
  - 10: 48-bit response, CRC and index checked.
  - 11: 48-bit response, no CRC or index check (R3).
  - 01: reserved; behaves as 10.
- Frame layout, MSB first:
  - [47] = 0 (start bit).
  - [46] = 1 (transmission bit).
  - [45:40] = index.
  - [39:8] = arg.
  - [7:1] = CRC7 over bits [47:8], polynomial x^7+x^3+1, initial value 0.
  - [0] = 1 (end bit).
- CRC7 is computed serially while bits are shifted out.
- State machine; all transitions except IDLE->SEND and DONE->IDLE occur only on bit_en cycles:
  - IDLE: cmd_oe=0, cmd_out=1. A 0x00E write moves to SEND, clears all error flags and sets busy.
  - SEND: drives 48 bits, one per bit_en tick. After the end bit, goes to TURN, or to DONE if rsp_type=00.
  - TURN: cmd_oe=0 for TURN_BITS ticks, then WAIT.
  - WAIT: each tick samples cmd_in. cmd_in=0 goes to RECV, with the start bit counted as received bit 47. If TIMEOUT_BITS ticks pass without cmd_in=0, sets timeout_err and goes to DONE.
  - RECV: samples 47 more bits with a running CRC7 over received bits [47:8], then goes to DONE.
  - DONE: registers the checks, pulses cmd_done for one CLK, clears busy, returns to IDLE.
- Response checks:
  - crc_err: received [7:1] differs from the computed CRC.
  - end_err: bit 0 is 0.
  - index_err: received [45:40] differs from the sent index.
  - crc_err and index_err are suppressed for type 11.
  - rsp_index and rsp_arg update in DONE when a response was received; on timeout they hold their old values.

## Timing
- Reset values:
  - cmd_out=1, cmd_oe=0, busy=0, cmd_done=0.
  - All error flags 0.
  - rsp_index=0, rsp_arg=0, arg=0, index=0, rsp_type=0.
  - State IDLE.
- Reset mid-command aborts immediately to IDLE with the above values; no cmd_done pulse.
- The 0x00E write at edge T sets busy at T.
- Start bit timing: cmd_oe=1 and cmd_out=0 are registered on the first edge after T with bit_en=1. Each subsequent bit_en edge presents the next bit.
- With bit_en tied high: bits occupy cycles T+1..T+48, and cmd_oe falls at T+49.
- With bit_en tied high and rsp_type=00: cmd_done pulses at T+50.
- With bit_en tied high and a response: cmd_done pulses 1 CLK after the edge sampling the response end bit.
- cmd_in is sampled on bit_en edges only. bit_en gaps stretch all intervals without changing results.
- A 0x00E write in the same cycle as the cmd_done pulse is ignored, since busy is still 1.

## Test plan
- CMD0: arg=0, index 0, rsp_type 00, bit_en=1 -> frame 0x40_0000_0000_95 on cmd_out; cmd_done at T+50; no errors.
- CMD8: arg=0x000001AA, rsp_type 10. Card replies 0x48_0000_01AA_87 starting 3 bit-times after release -> rsp_index=8, rsp_arg=0x000001AA, all errors 0.
- CMD17 timeout: arg=0, rsp_type 10, no reply -> frame byte 0x55 as the last byte; timeout_err=1 after 2+64 ticks; rsp_arg unchanged.
- Bad reply to CMD8: last byte 0x86, then separately index 9 with correct CRC -> end_err=1 in the first case; index_err=1 in the second with crc_err=0.
- Write to 0x00E with wr_data 0x1933 while busy -> ignored. Second command issued after cmd_done -> index 0x19, type 11; reply with wrong CRC -> crc_err=0.
- bit_en toggling every 4th cycle, plus RESET asserted mid-SEND -> frame bits stretched 4x with the same content; after reset cmd_oe=0, busy=0, no cmd_done.
